// File: rtl/motor_pkg.sv
// Shared definitions for the H-bridge PWM driver: direction codes, BCD limits,
// channel state encoding and the BCD helpers used by the timebase and channels.
package motor_pkg;

    localparam logic [1:0]  DIR_FWD   = 2'b10;
    localparam logic [1:0]  DIR_REV   = 2'b01;
    localparam logic [1:0]  DIR_COAST = 2'b00;
    localparam logic [1:0]  DIR_BRAKE = 2'b11;

    localparam logic [11:0] BCD_MAX   = 12'h999;

    typedef enum logic {
        RUN,
        DEAD
    } chan_state_e;

    function automatic logic bcd_valid(input logic [11:0] v);
        return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Three-digit BCD increment; 999 rolls over to 000 through the digit carries.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r[7:4] = 4'd0;
                if (v[11:8] == 4'd9) begin
                    r[11:8] = 4'd0;
                end else begin
                    r[11:8] = v[11:8] + 4'd1;
                end
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/canal_motor.sv
// One H-bridge channel: samples its command at period boundaries, forces a
// dead-time interval on forward/reverse reversals and drives registered EN/IN pins.
module canal_motor
    import motor_pkg::*;
#(
    parameter int DEAD_TIME_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boundary_i,
    input  logic        enable_i,
    input  logic [1:0]  dir_i,
    input  logic [11:0] duty_i,
    input  logic [11:0] count_i,
    output logic        en_o,
    output logic        in_a_o,
    output logic        in_b_o,
    output logic        bcd_err_o
);

    localparam int DW = $clog2(DEAD_TIME_PERIODS + 1);

    chan_state_e   state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [11:0]   duty_q, duty_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          err_q, err_d;
    logic          en_q, in_a_q, in_b_q;

    logic [1:0]    effDir;
    logic [11:0]   effDuty;
    logic          dutyBad;
    logic          reversal;
    logic          pinEn, pinA, pinB;

    // Effective command, next applied state and pin values for the current counter.
    always_comb begin
        effDir   = enable_i ? dir_i : DIR_COAST;
        dutyBad  = enable_i && !bcd_valid(duty_i);
        if (!enable_i) begin
            effDuty = '0;
        end else if (dutyBad) begin
            effDuty = BCD_MAX;
        end else begin
            effDuty = duty_i;
        end
        reversal = ((effDir == DIR_FWD) && (dir_q == DIR_REV)) ||
                   ((effDir == DIR_REV) && (dir_q == DIR_FWD));

        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        err_d   = err_q;

        if (boundary_i) begin
            unique case (state_q)
                RUN: begin
                    err_d = err_q | dutyBad;
                    if (reversal) begin
                        state_d = DEAD;
                        dead_d  = DW'(DEAD_TIME_PERIODS);
                        dir_d   = DIR_COAST;
                        duty_d  = '0;
                    end else begin
                        dir_d  = effDir;
                        duty_d = effDuty;
                    end
                end
                DEAD: begin
                    if (dead_q <= DW'(1)) begin
                        state_d = RUN;
                        dead_d  = '0;
                        dir_d   = effDir;
                        duty_d  = effDuty;
                        err_d   = err_q | dutyBad;
                    end else begin
                        dead_d = dead_q - DW'(1);
                    end
                end
            endcase
        end

        pinEn = 1'b0;
        pinA  = 1'b0;
        pinB  = 1'b0;
        unique case (dir_q)
            DIR_FWD: begin
                pinA  = 1'b1;
                pinEn = (count_i < duty_q);
            end
            DIR_REV: begin
                pinB  = 1'b1;
                pinEn = (count_i < duty_q);
            end
            DIR_BRAKE: begin
                pinA  = 1'b1;
                pinB  = 1'b1;
                pinEn = 1'b1;
            end
            default: begin
                pinEn = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            dir_q   <= DIR_COAST;
            duty_q  <= '0;
            dead_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            in_a_q  <= 1'b0;
            in_b_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            err_q   <= err_d;
            en_q    <= pinEn;
            in_a_q  <= pinA;
            in_b_q  <= pinB;
        end
    end

    assign en_o      = en_q;
    assign in_a_o    = in_a_q;
    assign in_b_o    = in_b_q;
    assign bcd_err_o = err_q;

endmodule

// File: rtl/driver_motoare_pwm.sv
// Motor PWM back end: shared prescaler and 3-digit BCD period counter feeding
// two independent H-bridge channels (driver A and driver B).
module driver_motoare_pwm
    import motor_pkg::*;
#(
    parameter int PRESCALER         = 50,
    parameter int DEAD_TIME_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic        ena,
    output logic        in1,
    output logic        in2,
    output logic        enb,
    output logic        in3,
    output logic        in4,
    output logic        period_start,
    output logic        bcd_err_a,
    output logic        bcd_err_b
);

    localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   count_q, count_d;
    logic          ps_q;
    logic          tick;
    logic          boundary;

    // The boundary is the tick that rolls the counter from 999 back to 000.
    always_comb begin
        tick     = (presc_q == PW'(PRESCALER - 1));
        boundary = tick && (count_q == BCD_MAX);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        count_d  = tick ? bcd_inc(count_q) : count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= '0;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            ps_q    <= boundary;
        end
    end

    assign period_start = ps_q;

    canal_motor #(
        .DEAD_TIME_PERIODS(DEAD_TIME_PERIODS)
    ) u_canal_a (
        .clk       (clk),
        .rst       (rst),
        .boundary_i(boundary),
        .enable_i  (enable),
        .dir_i     (directie_driverA),
        .duty_i    (factor_dc_driverA),
        .count_i   (count_q),
        .en_o      (ena),
        .in_a_o    (in1),
        .in_b_o    (in2),
        .bcd_err_o (bcd_err_a)
    );

    canal_motor #(
        .DEAD_TIME_PERIODS(DEAD_TIME_PERIODS)
    ) u_canal_b (
        .clk       (clk),
        .rst       (rst),
        .boundary_i(boundary),
        .enable_i  (enable),
        .dir_i     (directie_driverB),
        .duty_i    (factor_dc_driverB),
        .count_i   (count_q),
        .en_o      (enb),
        .in_a_o    (in3),
        .in_b_o    (in4),
        .bcd_err_o (bcd_err_b)
    );

endmodule

// File: tb/tb_driver_motoare_pwm.sv
// Directed bench for driver_motoare_pwm with PRESCALER=2 (2000-clk periods) and
// two dead-time periods; each scenario task checks its own hand-computed values.
module tb_driver_motoare_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  dirA, dirB;
    logic [11:0] dutyA, dutyB;
    logic        ena, in1, in2, enb, in3, in4;
    logic        period_start, bcd_err_a, bcd_err_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    driver_motoare_pwm #(
        .PRESCALER        (2),
        .DEAD_TIME_PERIODS(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .directie_driverA (dirA),
        .directie_driverB (dirB),
        .factor_dc_driverA(dutyA),
        .factor_dc_driverB(dutyB),
        .ena              (ena),
        .in1              (in1),
        .in2              (in2),
        .enb              (enb),
        .in3              (in3),
        .in4              (in4),
        .period_start     (period_start),
        .bcd_err_a        (bcd_err_a),
        .bcd_err_b        (bcd_err_b)
    );

    // Bounded wait for the first period_start after reset release.
    task automatic wait_first_boundary(output int cycles, output bit activity);
        cycles   = 0;
        activity = 1'b0;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            cycles = i;
            if ({ena, in1, in2, enb, in3, in4} !== 6'b0) activity = 1'b1;
            if (period_start === 1'b1) break;
        end
    endtask

    // Called in the period_start cycle; observes the following full period.
    task automatic measure_period(output int enaHi, output int enbHi,
                                  output logic [1:0] inA, output logic [1:0] inB,
                                  output bit stable, output bit psOk);
        enaHi  = 0;
        enbHi  = 0;
        inA    = 2'bxx;
        inB    = 2'bxx;
        stable = 1'b1;
        psOk   = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                inA = {in1, in2};
                inB = {in3, in4};
            end else if (({in1, in2} !== inA) || ({in3, in4} !== inB)) begin
                stable = 1'b0;
            end
            if (ena === 1'b1) enaHi++;
            if (enb === 1'b1) enbHi++;
            if (period_start !== ((i == 1999) ? 1'b1 : 1'b0)) psOk = 1'b0;
        end
    endtask

    task automatic test_reset();
        int cycles;
        bit activity;
        rst    = 1'b1;
        enable = 1'b1;
        dirA   = 2'b00;
        dirB   = 2'b00;
        dutyA  = 12'h000;
        dutyB  = 12'h000;
        repeat (3) @(negedge clk);
        checks++;
        if ({ena, in1, in2, enb, in3, in4, period_start, bcd_err_a, bcd_err_b} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b want 000000000",
                     {ena, in1, in2, enb, in3, in4, period_start, bcd_err_a, bcd_err_b});
        end
        rst = 1'b0;
        wait_first_boundary(cycles, activity);
        checks++;
        if (cycles !== 2000) begin
            errors++;
            $display("[TB] FAIL reset_first_boundary: got %0d clk want 2000", cycles);
        end
        checks++;
        if (activity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_quiet: got activity=%0d want 0", activity);
        end
    endtask

    task automatic test_duty();
        int enaHi, enbHi;
        logic [1:0] inA, inB;
        bit stable, psOk;
        dirA  = 2'b10;
        dutyA = 12'h250;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if ({enaHi, inA} !== {32'd0, 2'b00}) begin
            errors++;
            $display("[TB] FAIL duty_before_boundary: got ena_hi=%0d in=%b want 0 00", enaHi, inA);
        end
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enaHi !== 500) begin
            errors++;
            $display("[TB] FAIL duty_ena_high: got %0d want 500", enaHi);
        end
        checks++;
        if (inA !== 2'b10 || stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL duty_in_pins: got in=%b stable=%0d want 10 1", inA, stable);
        end
        checks++;
        if (psOk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL duty_period_start: got ok=%0d want 1", psOk);
        end
    endtask

    task automatic test_reversal();
        int enaHi, enbHi;
        logic [1:0] inA, inB;
        bit stable, psOk;
        dirA = 2'b01;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enaHi !== 500 || inA !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rev_still_fwd: got ena_hi=%0d in=%b want 500 10", enaHi, inA);
        end
        for (int p = 0; p < 2; p++) begin
            measure_period(enaHi, enbHi, inA, inB, stable, psOk);
            checks++;
            if (enaHi !== 0 || inA !== 2'b00 || stable !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rev_dead_%0d: got ena_hi=%0d in=%b stable=%0d want 0 00 1",
                         p, enaHi, inA, stable);
            end
        end
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enaHi !== 500 || inA !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rev_after_dead: got ena_hi=%0d in=%b want 500 01", enaHi, inA);
        end
    endtask

    task automatic test_brake_coast();
        int enaHi, enbHi;
        logic [1:0] inA, inB;
        bit stable, psOk;
        dirB  = 2'b11;
        dutyB = 12'h000;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enbHi !== 0 || inB !== 2'b00) begin
            errors++;
            $display("[TB] FAIL brake_pending: got enb_hi=%0d in=%b want 0 00", enbHi, inB);
        end
        dirB = 2'b00;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enbHi !== 2000 || inB !== 2'b11 || stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL brake_applied: got enb_hi=%0d in=%b stable=%0d want 2000 11 1",
                     enbHi, inB, stable);
        end
        checks++;
        if (enaHi !== 500 || inA !== 2'b01) begin
            errors++;
            $display("[TB] FAIL brake_a_independent: got ena_hi=%0d in=%b want 500 01", enaHi, inA);
        end
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enbHi !== 0 || inB !== 2'b00) begin
            errors++;
            $display("[TB] FAIL coast_applied: got enb_hi=%0d in=%b want 0 00", enbHi, inB);
        end
    endtask

    task automatic test_bad_bcd_enable();
        int enaHi, enbHi;
        logic [1:0] inA, inB;
        bit stable, psOk;
        checks++;
        if (bcd_err_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bcd_err_initial: got %b want 0", bcd_err_a);
        end
        dutyA = 12'h9A0;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enaHi !== 1998 || inA !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bcd_duty_999: got ena_hi=%0d in=%b want 1998 01", enaHi, inA);
        end
        checks++;
        if ({bcd_err_a, bcd_err_b} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bcd_err_flags: got %b want 10", {bcd_err_a, bcd_err_b});
        end
        dutyA  = 12'h250;
        enable = 1'b0;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if ({enaHi, enbHi} !== {32'd0, 32'd0} || {inA, inB} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL enable_coast: got ena_hi=%0d enb_hi=%0d in=%b%b want 0 0 0000",
                     enaHi, enbHi, inA, inB);
        end
        checks++;
        if (bcd_err_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bcd_err_sticky: got %b want 1", bcd_err_a);
        end
    endtask

    task automatic test_reset_mid_dead();
        int enaHi, enbHi, cycles;
        logic [1:0] inA, inB;
        bit stable, psOk, activity;
        enable = 1'b1;
        dirA   = 2'b10;
        dutyA  = 12'h250;
        dirB   = 2'b11;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        dirA = 2'b01;
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enaHi !== 500 || enbHi !== 2000) begin
            errors++;
            $display("[TB] FAIL pre_dead: got ena_hi=%0d enb_hi=%0d want 500 2000", enaHi, enbHi);
        end
        repeat (300) @(negedge clk);
        checks++;
        if ({ena, in1, in2, enb, in3, in4} !== 6'b000111) begin
            errors++;
            $display("[TB] FAIL mid_dead_pins: got %b want 000111", {ena, in1, in2, enb, in3, in4});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ena, in1, in2, enb, in3, in4, period_start, bcd_err_a, bcd_err_b} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b want 000000000",
                     {ena, in1, in2, enb, in3, in4, period_start, bcd_err_a, bcd_err_b});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_first_boundary(cycles, activity);
        checks++;
        if (cycles !== 2000 || activity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet: got cycles=%0d activity=%0d want 2000 0",
                     cycles, activity);
        end
        measure_period(enaHi, enbHi, inA, inB, stable, psOk);
        checks++;
        if (enaHi !== 500 || inA !== 2'b01) begin
            errors++;
            $display("[TB] FAIL post_reset_rev: got ena_hi=%0d in=%b want 500 01", enaHi, inA);
        end
        checks++;
        if (enbHi !== 2000 || inB !== 2'b11 || bcd_err_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_b: got enb_hi=%0d in=%b err_a=%b want 2000 11 0",
                     enbHi, inB, bcd_err_a);
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_reversal();
        test_brake_coast();
        test_bad_bcd_enable();
        test_reset_mid_dead();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish by 2000000 ns want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/driver_motoare_pwm.md
# driver_motoare_pwm

Back end of the motor command path. Consumes the per-driver direction codes and 3-digit BCD duty factors produced by the movement logic and generates the H-bridge control pins (ENx PWM, INx direction) for drivers A and B. Commands are applied only at PWM period boundaries so the outputs never glitch mid-period. A forward↔reverse reversal is forced through a dead-time interval.

## Interface
Parameters:
- PRESCALER, 50: clk cycles per BCD count step. PWM period = 1000·PRESCALER clk (1 kHz at 50 MHz). Legal range ≥1.
- DEAD_TIME_PERIODS, 2: full PWM periods with the bridge idle on a 10↔01 reversal. Legal range ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  global run enable; sampled at period boundary.
- directie_driverA, directie_driverB  in  2 each  command: 10 forward, 01 reverse, 00 coast, 11 brake.
- factor_dc_driverA, factor_dc_driverB  in  12 each  duty, 3 BCD digits 000..999.
- ena, in1, in2  out  1 each  driver A pins.
- enb, in3, in4  out  1 each  driver B pins.
- period_start  out  1  one-clk pulse when the BCD counter wraps 999→000.
- bcd_err_a, bcd_err_b  out  1 each  sticky flag: an invalid BCD digit was sampled.

## Operation
- Shared timebase: prescaler 0..PRESCALER-1. On its terminal value it emits a tick and the 3-digit BCD counter increments. Digit carry is 9→0. Wrap is 999→000.
- Boundary = the clk edge where tick=1 and counter=999. period_start is high for that cycle.
- At each boundary, each channel samples its command:
  - If enable=0, the effective command is dir 00, duty 000.
  - If any duty nibble >9, the duty is replaced by 999 and bcd_err_x is set. bcd_err_x clears only on rst.
- Channel FSM, states RUN and DEAD:
  - RUN, sampled dir is the opposite polarity of the applied dir (10→01 or 01→10): go to DEAD, dead_cnt=DEAD_TIME_PERIODS, applied dir=00, duty=000.
  - RUN, any other sampled dir: apply the sampled dir and duty directly. Transitions through 00 or 11 never trigger DEAD.
  - DEAD: decrement dead_cnt at each boundary. Commands are ignored. At the boundary where dead_cnt reaches 0, latch the command currently on the inputs and return to RUN.
- Pin mapping per applied dir:
  - 10: IN=10, EN=(counter < duty).
  - 01: IN=01, EN=(counter < duty).
  - 00: IN=00, EN=0.
  - 11: IN=11, EN=1 (full brake, duty ignored).
- Compare is done on BCD values. Duty 000 gives EN constantly 0; duty 999 gives EN low only at count 999.

## Timing
- All outputs are registered.
- Pin outputs reflect the counter value and applied state of the previous clk, so EN/IN lag the counter by 1 clk.
- Applied state changes at the boundary. New pin values appear 1 clk after the boundary and hold for exactly one period.
- Command latency: worst case 1000·PRESCALER+1 clk. Reversal latency: (DEAD_TIME_PERIODS+1) periods +1 clk.
- EN high time per period = duty_decimal·PRESCALER clk.
- Reset values:
  - prescaler 0, counter 000.
  - both channels RUN, dir 00, duty 000, dead_cnt 0.
  - ena=enb=in1..in4=0, period_start=0, bcd_err_a=bcd_err_b=0.
- Reset asserted mid-DEAD or mid-period returns the block to the reset state immediately. After release the first boundary comes after 1000·PRESCALER clk.
- Input changes between boundaries have no effect.
- Both channels sample at the same edge and are independent of each other.

## Structure
- Package motor_pkg holds:
  - direction codes: DIR_FWD=2'b10, DIR_REV=2'b01, DIR_COAST=2'b00, DIR_BRAKE=2'b11.
  - BCD_MAX=12'h999.
  - channel state enum {RUN, DEAD}.
- Sub-module canal_motor holds one channel: sampling, BCD validity check, FSM, dead counter, compare, pin registers. It is instantiated twice.
- The top level holds the prescaler, the BCD counter and the period_start logic.

## Test plan
Sim parameters: PRESCALER=2, DEAD_TIME_PERIODS=2, enable=1 unless stated.
- Duty: dirA=10, dutyA=12'h250 → after first boundary, in1=1, in2=0, ena high 500 clk per 2000-clk period; period_start pulses every 2000 clk.
- Reversal: dirA 10→01 mid-period → at next boundary in1=in2=ena=0 for exactly 2 periods, then in1=0, in2=1 with PWM.
- Brake and coast: dirB=11 → in3=in4=enb=1 from the next boundary. Then dirB=00 → all 0, with no DEAD interval.
- Bad BCD and enable: dutyA=12'h9A0 → bcd_err_a=1 and ena low only at count 999. enable=0 → both channels coast from the next boundary.
- Reset mid-DEAD: assert rst → all outputs 0 asynchronously. After release, no output activity before 2000 clk.
